line_buffer_3row: RTL and testbench
===================================

Name: line_buffer_3row

Overview:
- Producer side of the 3x3 window interface: turns one raster pixel stream into three vertically aligned row taps (`dout1`, `dout2`, `dout3`) plus a qualifying valid.
- Sits between the video/capture source and the 3x3 matrix/edge-detection stage. Its outputs feed that stage's `din1`/`din2`/`din3` and `valid_in` directly.
- Holds the two previous image lines in on-chip line RAMs.

Parameters:
- `WIDTH`, 24: pixel width in bits (RGB888; the downstream stage uses bits [7:0]).
- `PIC_WIDTH`, 320: pixels per line. Legal range 4..512.
- `PIC_HEIGHT`, 240: lines per frame. Legal range 3..1024.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `valid_in`, input, 1: `din` carries a pixel this cycle.
- `sof`, input, 1: start of frame. Only sampled when `valid_in` is high; marks the current pixel as (row 0, col 0).
- `din`, input, `WIDTH`: incoming pixel, raster order.
- `valid_out`, output, 1: `dout1`..`dout3` form a valid column this cycle.
- `dout1`, output, `WIDTH`: pixel from row y-2, same column.
- `dout2`, output, `WIDTH`: pixel from row y-1, same column.
- `dout3`, output, `WIDTH`: current pixel, row y (registered `din`).
- `col`, output, `$clog2(PIC_WIDTH)`: column index of the pixel on `dout3`.

Behaviour:
- **Reset.** Synchronous: on a `clk` edge with `rst_n`=0, clear `valid_out`, `dout1`, `dout2`, `dout3`, `col`, the column counter, the row counter and the primed count. Line RAM contents are not cleared; they are never exposed before priming.
- **Column counter (`col_cnt`).**
  - Advances only on `valid_in`.
  - Wraps `PIC_WIDTH`-1 -> 0; the wrap increments the row counter.
  - Holds during `valid_in`=0 gaps; gaps never reset it.
- **Row counter.** Wraps `PIC_HEIGHT`-1 -> 0 at the end of the last column.
- **Primed count.** Saturating 0..2. Increments on each line completion and resets to 0 at frame wrap or on `sof`.
- **`sof` with `valid_in`.** The current pixel is treated as col 0, row 0, primed=0. Counters then continue from col 1. `sof` mid-line discards the partial line.
- **Line RAMs.** Two simple dual-port RAMs, A and B, each `PIC_WIDTH` x `WIDTH`, synchronous read, read-old-data.
  - Cycle t (`valid_in`=1, column c): read A[c] and B[c]; write A[c] <= `din`.
  - Cycle t+1: write B[c_d] <= the A read data (the old row y-1 value), using the delayed column address.
  - Result: A holds row y-1 and B holds row y-2.
- **Latency.** Exactly 1 cycle. A pixel accepted at edge t appears at t+1:
  - `dout3` = `din`(t)
  - `dout2` = A read data
  - `dout1` = B read data
  - `col` = c
  - `valid_out`=1 if primed==2 at acceptance (rows 2..`PIC_HEIGHT`-1), else 0.
- **Idle cycles.** When `valid_in`=0: `valid_out`=0 the following cycle; `dout*` and `col` hold their last values; no RAM writes except a pending B write from the prior cycle.
- **Frame wrap.** The first two rows of every frame give `valid_out`=0, the same as after reset.
- **Border handling.** No padding and no replication. The output column is raw; the downstream stage owns border logic.
- **No backpressure.** The downstream stage always accepts.

Decomposition:
- Shared package:
  - `PIX_W`=24
  - default `PIC_WIDTH` / `PIC_HEIGHT`
  - column and row counter width localparams derived with `$clog2`
  - the pixel typedef used by both this block and the matrix stage
- One natural sub-module: `line_ram_sdp`. Parameterised depth/width, one write port, one synchronous read port, read-old-data on same-address collision. It is instantiated twice.
- Counters and the output register stay in the top level.

Test Plan:
- **Reset + priming.** `PIC_WIDTH`=4, `PIC_HEIGHT`=4, `sof` on the first pixel, continuous `valid_in`, `din` = row*16+col. Required: `valid_out`=0 for the first 8 pixels. On the cycle after pixel 0x20 is accepted: `valid_out`=1, `dout1`=0x00, `dout2`=0x10, `dout3`=0x20, `col`=0. Then 0x01/0x11/0x21, etc.
- **Gaps.** Same stream with `valid_in` low every other cycle. Required:
  - columns are identical to the gap-free run;
  - `valid_out` pulses only on cycles after accepted pixels;
  - `dout*` hold during gaps.
- **Frame wrap.** Feed 16 pixels, then 16 more without `sof`, values 0x100+row*16+col. Required:
  - no `valid_out` for the first 8 pixels of the second frame;
  - the first valid column is `dout1`=0x100, `dout2`=0x110, `dout3`=0x120.
- **Mid-line `sof`.** Assert `sof` on col 2 of row 3. Required:
  - that pixel is reported as col 0;
  - priming restarts;
  - `valid_out` stays 0 for the next 8 accepted pixels.
- **Reset mid-frame.** Drop `rst_n` for 1 cycle while row 2 streams. Required:
  - the next cycle shows all outputs 0 and `valid_out`=0;
  - the subsequent stream primes from scratch.
- **Full width.** `PIC_WIDTH`=320 random data. A scoreboard model compares `dout1`/`dout2`/`dout3` against the stored rows y-2/y-1/y for every valid column across 3 frames, covering column wrap 319 -> 0.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// rtl/line_buffer_3row_pkg.sv - shared types and sizes for the 3-row line buffer and 3x3 window stage
package line_buffer_3row_pkg;

    localparam int PIX_W          = 24;
    localparam int DEF_PIC_WIDTH  = 320;
    localparam int DEF_PIC_HEIGHT = 240;
    localparam int COL_W          = $clog2(DEF_PIC_WIDTH);
    localparam int ROW_W          = $clog2(DEF_PIC_HEIGHT);

    // Number of completed lines needed before a full 3-row column exists.
    localparam int PRIMED_FULL    = 2;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [1:0]       primed_t;

endpackage

// File: rtl/line_ram_sdp.sv
// rtl/line_ram_sdp.sv - simple dual-port line RAM, synchronous read, read-old-data on collision
module line_ram_sdp
    import line_buffer_3row_pkg::*;
#(
    parameter int DEPTH  = DEF_PIC_WIDTH,
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; no reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; non-blocking update returns the pre-write word on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - raster stream to three vertically aligned row taps for the 3x3 window stage
module line_buffer_3row
    import line_buffer_3row_pkg::*;
#(
    parameter int WIDTH      = PIX_W,
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic                         sof,
    input  logic [WIDTH-1:0]             din,
    output logic                         valid_out,
    output logic [WIDTH-1:0]             dout1,
    output logic [WIDTH-1:0]             dout2,
    output logic [WIDTH-1:0]             dout3,
    output logic [$clog2(PIC_WIDTH)-1:0] col
);

    localparam int CW = $clog2(PIC_WIDTH);
    localparam int RW = $clog2(PIC_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
    localparam primed_t       PRIMED_MAX = primed_t'(PRIMED_FULL);

    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_cur;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] row_cur;
    logic [RW-1:0] row_nxt;
    primed_t       primed;
    primed_t       primed_cur;
    primed_t       primed_nxt;

    logic             acc_d;
    logic             a_wr_en;
    logic [WIDTH-1:0] a_rdata;
    logic [WIDTH-1:0] b_rdata;

    // Position of the pixel being accepted (sof forces row 0 col 0, unprimed) and where counters go next.
    always_comb begin
        col_cur    = sof ? '0 : col_cnt;
        row_cur    = sof ? '0 : row_cnt;
        primed_cur = sof ? '0 : primed;
        col_nxt    = col_cur + CW'(1);
        row_nxt    = row_cur;
        primed_nxt = primed_cur;
        if (col_cur == COL_LAST) begin
            col_nxt = '0;
            if (row_cur == ROW_LAST) begin
                row_nxt    = '0;
                primed_nxt = '0;
            end else begin
                row_nxt    = row_cur + RW'(1);
                primed_nxt = (primed_cur == PRIMED_MAX) ? PRIMED_MAX : primed_cur + 2'd1;
            end
        end
    end

    // Column/row/primed counters advance only on accepted pixels; idle cycles leave them untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            primed  <= '0;
        end else if (valid_in) begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
            primed  <= primed_nxt;
        end
    end

    // Output register: current pixel, its column and the one-cycle valid; holds across gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            dout3     <= '0;
            col       <= '0;
            acc_d     <= 1'b0;
        end else begin
            valid_out <= valid_in && (primed_cur == PRIMED_MAX);
            acc_d     <= valid_in;
            if (valid_in) begin
                dout3 <= din;
                col   <= col_cur;
            end
        end
    end

    assign a_wr_en = valid_in & rst_n;

    // Line A holds row y-1: read old value and overwrite with the incoming pixel in the same cycle.
    line_ram_sdp #(
        .DEPTH  (PIC_WIDTH),
        .DATA_W (WIDTH),
        .ADDR_W (CW)
    ) u_line_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (a_wr_en),
        .wr_addr (col_cur),
        .wr_data (din),
        .rd_en   (valid_in),
        .rd_addr (col_cur),
        .rd_data (a_rdata)
    );

    // Line B holds row y-2: one cycle later it takes the old A word at the delayed column (the col register).
    line_ram_sdp #(
        .DEPTH  (PIC_WIDTH),
        .DATA_W (WIDTH),
        .ADDR_W (CW)
    ) u_line_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (acc_d),
        .wr_addr (col),
        .wr_data (a_rdata),
        .rd_en   (valid_in),
        .rd_addr (col_cur),
        .rd_data (b_rdata)
    );

    assign dout2 = a_rdata;
    assign dout1 = b_rdata;

endmodule

// File: tb/tb_line_buffer_3row.sv
// tb/tb_line_buffer_3row.sv - directed self-checking bench for line_buffer_3row
module tb_line_buffer_3row;
    import line_buffer_3row_pkg::*;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int FW = 320;
    localparam int FH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s_vin = 1'b0;
    logic        s_sof = 1'b0;
    logic [23:0] s_din = '0;
    logic        s_vout;
    logic [23:0] s_d1;
    logic [23:0] s_d2;
    logic [23:0] s_d3;
    logic [1:0]  s_col;

    logic        f_vin = 1'b0;
    logic        f_sof = 1'b0;
    logic [23:0] f_din = '0;
    logic        f_vout;
    logic [23:0] f_d1;
    logic [23:0] f_d2;
    logic [23:0] f_d3;
    logic [8:0]  f_col;

    logic [23:0] img [FH][FW];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    line_buffer_3row #(.WIDTH(24), .PIC_WIDTH(SW), .PIC_HEIGHT(SH)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (s_vin),
        .sof       (s_sof),
        .din       (s_din),
        .valid_out (s_vout),
        .dout1     (s_d1),
        .dout2     (s_d2),
        .dout3     (s_d3),
        .col       (s_col)
    );

    line_buffer_3row #(.WIDTH(24), .PIC_WIDTH(FW), .PIC_HEIGHT(FH)) dut_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (f_vin),
        .sof       (f_sof),
        .din       (f_din),
        .valid_out (f_vout),
        .dout1     (f_d1),
        .dout2     (f_d2),
        .dout3     (f_d3),
        .col       (f_col)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_s(input logic v, input logic s, input logic [23:0] d);
        s_vin = v;
        s_sof = s;
        s_din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_f(input logic v, input logic s, input logic [23:0] d);
        f_vin = v;
        f_sof = s;
        f_din = d;
        @(posedge clk);
        #1;
    endtask

    // One 4x4 frame of base+row*16+col, optionally with an idle cycle after every pixel.
    task automatic run_frame(input logic [23:0] base, input bit use_sof, input bit gaps);
        logic [23:0] px;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                px = base + 24'(r * 16 + c);
                step_s(1'b1, use_sof && r == 0 && c == 0, px);
                check("vout", 32'(s_vout), 32'(r >= 2));
                check("col", 32'(s_col), 32'(c));
                check("dout3", 32'(s_d3), 32'(px));
                if (r >= 2) begin
                    check("dout1", 32'(s_d1), 32'(px - 24'h20));
                    check("dout2", 32'(s_d2), 32'(px - 24'h10));
                end
                if (gaps) begin
                    step_s(1'b0, 1'b0, 24'hABCDEF);
                    check("gap_vout", 32'(s_vout), 32'd0);
                    check("gap_col", 32'(s_col), 32'(c));
                    check("gap_dout3", 32'(s_d3), 32'(px));
                    if (r >= 2) begin
                        check("gap_dout1", 32'(s_d1), 32'(px - 24'h20));
                        check("gap_dout2", 32'(s_d2), 32'(px - 24'h10));
                    end
                end
            end
        end
    endtask

    initial begin
        logic [23:0] d;

        #1;
        rst_n = 1'b0;
        step_s(1'b0, 1'b0, 24'h0);
        step_s(1'b1, 1'b0, 24'h55);
        check("rst_vout", 32'(s_vout), 32'd0);
        check("rst_dout1", 32'(s_d1), 32'd0);
        check("rst_dout2", 32'(s_d2), 32'd0);
        check("rst_dout3", 32'(s_d3), 32'd0);
        check("rst_col", 32'(s_col), 32'd0);
        check("rst_full_vout", 32'(f_vout), 32'd0);
        rst_n = 1'b1;
        step_s(1'b0, 1'b0, 24'h0);

        run_frame(24'h000, 1'b1, 1'b0);
        run_frame(24'h000, 1'b1, 1'b1);
        run_frame(24'h100, 1'b0, 1'b0);

        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                if (r == 3 && c == 2) break;
                step_s(1'b1, r == 0 && c == 0, 24'h200 + 24'(r * 16 + c));
            end
        end
        check("pre_sof_vout", 32'(s_vout), 32'd1);
        check("pre_sof_dout1", 32'(s_d1), 32'h211);
        run_frame(24'h300, 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < SW; c++) begin
                if (r == 2 && c == 2) break;
                step_s(1'b1, r == 0 && c == 0, 24'h400 + 24'(r * 16 + c));
            end
        end
        check("pre_rst_vout", 32'(s_vout), 32'd1);
        check("pre_rst_dout1", 32'(s_d1), 32'h401);
        rst_n = 1'b0;
        step_s(1'b1, 1'b0, 24'h422);
        rst_n = 1'b1;
        check("midrst_vout", 32'(s_vout), 32'd0);
        check("midrst_dout1", 32'(s_d1), 32'd0);
        check("midrst_dout2", 32'(s_d2), 32'd0);
        check("midrst_dout3", 32'(s_d3), 32'd0);
        check("midrst_col", 32'(s_col), 32'd0);
        run_frame(24'h500, 1'b0, 1'b0);

        s_vin = 1'b0;
        s_sof = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < FH; r++) begin
                for (int c = 0; c < FW; c++) begin
                    d = 24'($urandom);
                    img[r][c] = d;
                    step_f(1'b1, f == 0 && r == 0 && c == 0, d);
                    check("full_vout", 32'(f_vout), 32'(r >= 2));
                    check("full_col", 32'(f_col), 32'(c));
                    check("full_dout3", 32'(f_d3), 32'(d));
                    if (r >= 2) begin
                        check("full_dout1", 32'(f_d1), 32'(img[r-2][c]));
                        check("full_dout2", 32'(f_d2), 32'(img[r-1][c]));
                    end
                end
            end
        end
        step_f(1'b0, 1'b0, 24'h0);
        check("full_idle_vout", 32'(f_vout), 32'd0);
        check("full_idle_col", 32'(f_col), 32'(FW - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
